// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

   localparam int unsigned WB_ADDRESS_WIDTH = 5;
   localparam int unsigned WB_D_WIDTH       = 32;
   localparam int unsigned REG_X0           = 0;

   typedef struct packed {
      logic [WB_ADDRESS_WIDTH-1:0] rd;
      logic [WB_D_WIDTH-1:0]       data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_PIPE,
      WB_MD
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Registered FIFO of writeback requests; an entry pushed into an empty FIFO
// becomes visible at the head one cycle later.
module wb_fifo
   import wb_pkg::*;
#(
   parameter type         T     = wb_req_t,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  T                         data_i,
   input  logic                     pop_i,
   output T                         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   T                mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so pointer wrap is plain overflow
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and buffered mul/div results onto the
// register file write port and tracks pending mul/div destinations.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned D_WIDTH       = 32,
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned BUF_DEPTH     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_valid,
   input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
   input  logic [D_WIDTH-1:0]       pipe_data,
   input  logic                     md_valid,
   output logic                     md_ready,
   input  logic [ADDRESS_WIDTH-1:0] md_rd,
   input  logic [D_WIDTH-1:0]       md_data,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   input  logic [ADDRESS_WIDTH-1:0] rs1,
   input  logic [ADDRESS_WIDTH-1:0] rs2,
   output logic                     stall,
   output logic                     rf_wr_en,
   output logic [ADDRESS_WIDTH-1:0] rf_a3,
   output logic [D_WIDTH-1:0]       rf_din,
   output logic                     waw_err
);

   localparam int unsigned NREG = 2 ** ADDRESS_WIDTH;
   localparam int unsigned CW   = $clog2(BUF_DEPTH) + 1;
   localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(REG_X0);

   // Same layout as wb_req_t, sized by this instance's parameters
   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [D_WIDTH-1:0]       data;
   } req_t;

   req_t                     md_req, head;
   logic                     fifo_full, fifo_empty;
   logic [CW-1:0]            fifo_count;
   logic                     md_push, md_pop;
   wb_src_e                  sel;

   logic                     wr_en_q, wr_en_d;
   logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
   logic [D_WIDTH-1:0]       din_q, din_d;
   logic [NREG-1:0]          pend_q, pend_d;
   logic                     waw_q, waw_d;

   assign md_req   = '{rd: md_rd, data: md_data};
   assign md_ready = (fifo_count < CW'(BUF_DEPTH));
   assign md_push  = md_valid && !fifo_full;

   wb_fifo #(
      .T     (req_t),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (md_push),
      .data_i  (md_req),
      .pop_i   (md_pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign stall = ((rs1 != X0) && pend_q[rs1]) || ((rs2 != X0) && pend_q[rs2]);

   always_comb begin
      sel     = WB_NONE;
      wr_en_d = 1'b0;
      a3_d    = a3_q;
      din_d   = din_q;
      if (pipe_valid)       sel = WB_PIPE;
      else if (!fifo_empty) sel = WB_MD;
      md_pop = (sel == WB_MD);

      unique case (sel)
         WB_PIPE: begin
            a3_d    = pipe_rd;
            din_d   = pipe_data;
            wr_en_d = (pipe_rd != X0);
         end
         WB_MD: begin
            a3_d    = head.rd;
            din_d   = head.data;
            wr_en_d = (head.rd != X0);
         end
         default: ;
      endcase

      // Clear first so a same-cycle issue to the same index keeps it pending
      pend_d = pend_q;
      if (md_pop)      pend_d[head.rd]  = 1'b0;
      if (issue_valid) pend_d[issue_rd] = 1'b1;
      pend_d[0] = 1'b0;

      waw_d = waw_q | (pipe_valid && (pipe_rd != X0) && pend_q[pipe_rd]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q <= 1'b0;
         a3_q    <= '0;
         din_q   <= '0;
         pend_q  <= '0;
         waw_q   <= 1'b0;
      end else begin
         wr_en_q <= wr_en_d;
         a3_q    <= a3_d;
         din_q   <= din_d;
         pend_q  <= pend_d;
         waw_q   <= waw_d;
      end
   end

   assign rf_wr_en = wr_en_q;
   assign rf_a3    = a3_q;
   assign rf_din   = din_q;
   assign waw_err  = waw_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset corner cases, and
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1, rs2;
   logic        stall;
   logic        rf_wr_en;
   logic [4:0]  rf_a3;
   logic [31:0] rf_din;
   logic        waw_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_arbiter #(
      .D_WIDTH       (32),
      .ADDRESS_WIDTH (5),
      .BUF_DEPTH     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_valid  (pipe_valid),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .md_valid    (md_valid),
      .md_ready    (md_ready),
      .md_rd       (md_rd),
      .md_data     (md_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .stall       (stall),
      .rf_wr_en    (rf_wr_en),
      .rf_a3       (rf_a3),
      .rf_din      (rf_din),
      .waw_err     (waw_err)
   );

   // Register file stub sampling on the negedge
   logic [31:0] rf_mem [32];
   always @(negedge clk) if (rf_wr_en) rf_mem[rf_a3] <= rf_din;

   typedef struct {
      logic        pv;  logic [4:0] prd; logic [31:0] pdata;
      logic        mv;  logic [4:0] mrd; logic [31:0] mdata;
      logic        iv;  logic [4:0] ird;
      logic [4:0]  r1;  logic [4:0] r2;
      logic        e_rdy; logic e_stall;
      logic        e_wr;  logic [4:0] e_a3; logic [31:0] e_din; logic chk_ad;
   } vec_t;

   typedef struct { logic [4:0] rd; logic [31:0] data; } mreq_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic e_rdy, input logic e_stall,
                      input logic e_wr, input logic [4:0] e_a3, input logic [31:0] e_din,
                      input logic chk_ad);
      vec_t v;
      v.pv = pv; v.prd = prd; v.pdata = pdata;
      v.mv = mv; v.mrd = mrd; v.mdata = mdata;
      v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
      v.e_rdy = e_rdy; v.e_stall = e_stall;
      v.e_wr = e_wr; v.e_a3 = e_a3; v.e_din = e_din; v.chk_ad = chk_ad;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
      pipe_valid = pv; pipe_rd = prd; pipe_data = pdata;
      md_valid = mv; md_rd = mrd; md_data = mdata;
      issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      drive(v.pv, v.prd, v.pdata, v.mv, v.mrd, v.mdata, v.iv, v.ird, v.r1, v.r2);
      #1;
      chk($sformatf("row%0d md_ready", idx), 32'(md_ready), 32'(v.e_rdy));
      chk($sformatf("row%0d stall", idx), 32'(stall), 32'(v.e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d rf_wr_en", idx), 32'(rf_wr_en), 32'(v.e_wr));
      if (v.chk_ad) begin
         chk($sformatf("row%0d rf_a3", idx), 32'(rf_a3), 32'(v.e_a3));
         chk($sformatf("row%0d rf_din", idx), rf_din, v.e_din);
      end
      chk($sformatf("row%0d waw_err", idx), 32'(waw_err), 32'd0);
   endtask

   initial begin
      mreq_t       q[$];
      mreq_t       r;
      bit          mpend [32];
      logic        e_wr, e_rdy, e_stall;
      logic [4:0]  e_a3;
      logic [31:0] e_din;
      logic        pv, mv, iv;
      logic [4:0]  prd, mrd, ird, r1, r2;
      logic [31:0] pdata, mdata;

      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset rf_wr_en", 32'(rf_wr_en), 32'd0);
      chk("reset rf_a3", 32'(rf_a3), 32'd0);
      chk("reset rf_din", rf_din, 32'd0);
      chk("reset waw_err", 32'(waw_err), 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset md_ready", 32'(md_ready), 32'd1);

      //   pv prd pdata          mv mrd mdata         iv ird r1 r2  rdy stl  wr a3 din           ad
      add(1, 5, 32'hDEADBEEF,  0, 0, 0,            0, 0,  0, 0,  1, 0,   1, 5, 32'hDEADBEEF, 1);
      add(0, 0, 0,             0, 0, 0,            1, 7,  7, 0,  1, 0,   0, 5, 32'hDEADBEEF, 1);
      add(0, 0, 0,             1, 7, 32'h12,       0, 0,  7, 0,  1, 1,   0, 5, 32'hDEADBEEF, 1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  7, 0,  1, 1,   1, 7, 32'h12,       1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  7, 0,  1, 0,   0, 7, 32'h12,       1);
      add(1, 10, 32'hA0A0A0A0, 1, 3, 32'h33,       0, 0,  0, 0,  1, 0,   1, 10, 32'hA0A0A0A0, 1);
      add(1, 11, 32'hB1B1B1B1, 1, 4, 32'h44,       0, 0,  0, 0,  1, 0,   1, 11, 32'hB1B1B1B1, 1);
      add(1, 12, 32'hC2C2C2C2, 1, 13, 32'h55,      0, 0,  0, 0,  0, 0,   1, 12, 32'hC2C2C2C2, 1);
      add(1, 14, 32'hD3D3D3D3, 1, 13, 32'h55,      0, 0,  0, 0,  0, 0,   1, 14, 32'hD3D3D3D3, 1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  0, 0,   1, 3, 32'h33,       1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  1, 0,   1, 4, 32'h44,       1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  1, 0,   0, 4, 32'h44,       1);
      add(1, 0, 32'hFFFF,      0, 0, 0,            0, 0,  0, 0,  1, 0,   0, 0, 0,            0);
      add(0, 0, 0,             1, 0, 32'hFFFF,     0, 0,  0, 0,  1, 0,   0, 0, 0,            0);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  1, 0,   0, 0, 0,            0);
      add(1, 15, 32'hE4E4E4E4, 1, 0, 32'hFFFF,     0, 0,  0, 0,  1, 0,   1, 15, 32'hE4E4E4E4, 1);
      add(1, 16, 32'hF5F5F5F5, 1, 0, 32'hFFFF,     0, 0,  0, 0,  1, 0,   1, 16, 32'hF5F5F5F5, 1);
      add(1, 17, 32'h01234567, 0, 0, 0,            0, 0,  0, 0,  0, 0,   1, 17, 32'h01234567, 1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  0, 0,   0, 0, 0,            0);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  1, 0,   0, 0, 0,            0);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 0,  1, 0,   0, 0, 0,            0);
      add(0, 0, 0,             0, 0, 0,            1, 9,  0, 0,  1, 0,   0, 0, 0,            0);
      add(0, 0, 0,             1, 9, 32'h99,       0, 0,  0, 9,  1, 1,   0, 0, 0,            0);
      add(0, 0, 0,             0, 0, 0,            1, 9,  0, 9,  1, 1,   1, 9, 32'h99,       1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 9,  1, 1,   0, 9, 32'h99,       1);
      add(0, 0, 0,             1, 9, 32'h9A,       0, 0,  0, 9,  1, 1,   0, 9, 32'h99,       1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 9,  1, 1,   1, 9, 32'h9A,       1);
      add(0, 0, 0,             0, 0, 0,            0, 0,  0, 9,  1, 0,   0, 9, 32'h9A,       1);

      foreach (tbl[i]) apply(tbl[i], i);

      @(negedge clk);
      idle();
      #1;
      chk("rf x5", rf_mem[5], 32'hDEADBEEF);
      chk("rf x7", rf_mem[7], 32'h12);
      chk("rf x3", rf_mem[3], 32'h33);
      chk("rf x4", rf_mem[4], 32'h44);
      chk("rf x13 never written", rf_mem[13], 32'h0);

      // Reset with two buffered entries and x6 pending
      @(negedge clk);
      drive(1, 20, 32'h1, 1, 6, 32'h66, 1, 6, 0, 0);
      @(negedge clk);
      drive(1, 21, 32'h2, 1, 6, 32'h67, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
      #1;
      chk("prerst stall", 32'(stall), 32'd1);
      chk("prerst md_ready", 32'(md_ready), 32'd0);
      chk("prerst rf_wr_en", 32'(rf_wr_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst rf_wr_en", 32'(rf_wr_en), 32'd0);
      chk("midrst rf_a3", 32'(rf_a3), 32'd0);
      chk("midrst rf_din", rf_din, 32'd0);
      chk("midrst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst md_ready", 32'(md_ready), 32'd1);
      chk("postrst stall", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("postrst idle%0d rf_wr_en", i), 32'(rf_wr_en), 32'd0);
      end
      chk("rf x6 never written", rf_mem[6], 32'h0);

      // Randomized traffic against a queue/bit-array model
      for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         pv    = ($urandom_range(0, 1) == 1);
         prd   = 5'($urandom_range(0, 31));
         if (mpend[prd]) prd = 5'd0;
         pdata = $urandom;
         mv    = ($urandom_range(0, 1) == 1);
         mrd   = 5'($urandom_range(0, 31));
         mdata = $urandom;
         iv    = ($urandom_range(0, 3) == 0);
         ird   = 5'($urandom_range(1, 31));
         r1    = 5'($urandom_range(0, 31));
         r2    = 5'($urandom_range(0, 31));
         drive(pv, prd, pdata, mv, mrd, mdata, iv, ird, r1, r2);
         #1;
         e_rdy   = (q.size() < 2);
         e_stall = (r1 != 0 && mpend[r1]) || (r2 != 0 && mpend[r2]);
         chk($sformatf("rand%0d md_ready", c), 32'(md_ready), 32'(e_rdy));
         chk($sformatf("rand%0d stall", c), 32'(stall), 32'(e_stall));

         e_wr = 1'b0; e_a3 = '0; e_din = '0;
         if (pv) begin
            e_wr = (prd != 0); e_a3 = prd; e_din = pdata;
         end else if (q.size() > 0) begin
            r = q.pop_front();
            e_wr = (r.rd != 0); e_a3 = r.rd; e_din = r.data;
            mpend[r.rd] = 1'b0;
         end
         if (mv && e_rdy) q.push_back('{rd: mrd, data: mdata});
         if (iv) mpend[ird] = 1'b1;
         mpend[0] = 1'b0;

         @(posedge clk);
         #1;
         chk($sformatf("rand%0d rf_wr_en", c), 32'(rf_wr_en), 32'(e_wr));
         if (e_wr) begin
            chk($sformatf("rand%0d rf_a3", c), 32'(rf_a3), 32'(e_a3));
            chk($sformatf("rand%0d rf_din", c), rf_din, e_din);
         end
         chk($sformatf("rand%0d waw_err", c), 32'(waw_err), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; owns its single write port (write enable, destination address, write data).
- Merges two producers:
  - the in-order pipeline result (ALU/load), one per cycle, never back-pressured;
  - results from the multi-cycle mul/div unit, which complete out of order and are buffered.
- Keeps a pending-destination scoreboard and raises a stall when a decoding instruction reads a register whose mul/div result has not yet been written.

Parameters:
- D_WIDTH, 32, data width of register values.
- ADDRESS_WIDTH, 5, register index width.
- BUF_DEPTH, 2, mul/div result buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- pipe_valid  in  1  pipeline result valid this cycle.
- pipe_rd  in  ADDRESS_WIDTH  pipeline destination register.
- pipe_data  in  D_WIDTH  pipeline result.
- md_valid  in  1  mul/div result offered.
- md_ready  out  1  buffer can accept; transfer when md_valid&&md_ready.
- md_rd  in  ADDRESS_WIDTH  mul/div destination register.
- md_data  in  D_WIDTH  mul/div result.
- issue_valid  in  1  mul/div instruction issued this cycle.
- issue_rd  in  ADDRESS_WIDTH  destination of issued mul/div.
- rs1, rs2  in  ADDRESS_WIDTH  source registers of instruction in decode.
- stall  out  1  decode must hold.
- rf_wr_en  out  1  register file write enable.
- rf_a3  out  ADDRESS_WIDTH  register file write address.
- rf_din  out  D_WIDTH  register file write data.
- waw_err  out  1  sticky: pipeline wrote a register with a pending mul/div result.

Behaviour:
- Reset (async, immediate):
  - rf_wr_en=0, rf_a3=0, rf_din=0, waw_err=0.
  - Buffer empty, scoreboard all clear.
  - md_ready=1 once rst deasserts.
  - Reset mid-operation discards buffered results and pending bits.
- Output registers:
  - rf_* are registered on posedge, giving 1-cycle latency from input to rf_*.
  - The register file samples on the following negedge, so a value accepted in cycle N is readable in cycle N+1 after the negedge.
- Arbitration each cycle:
  - pipe_valid=1: the pipeline result is selected; the buffer is not popped.
  - else buffer non-empty: pop the oldest entry and select it.
  - else: rf_wr_en<=0; rf_a3 and rf_din hold their previous values.
- Writes to x0 are dropped:
  - the selected request with rd==0 gives rf_wr_en<=0;
  - a buffered x0 entry is still popped.
- Buffer:
  - FIFO of {rd,data}, depth BUF_DEPTH.
  - md_ready = (count<BUF_DEPTH), combinational from count only.
  - Push and pop in the same cycle leave count unchanged.
  - Push into an empty buffer cannot be popped in the same cycle (registered FIFO).
  - Pointers wrap modulo BUF_DEPTH.
- Scoreboard (2**ADDRESS_WIDTH bits, bit0 tied 0):
  - set bit[issue_rd] on issue_valid;
  - clear bit[rd] on the posedge a buffered entry is popped to rf_*;
  - if set and clear hit the same index in the same cycle, set wins.
- Stall:
  - stall = (rs1!=0 && pend[rs1]) || (rs2!=0 && pend[rs2]).
  - Combinational from scoreboard state; no bypass from md inputs.
  - A register becomes readable one cycle after its pending bit clears.
- waw_err:
  - set when pipe_valid && pipe_rd!=0 && pend[pipe_rd];
  - held until reset.
  - The hazard unit guarantees this never occurs; the bench checks it stays 0.
- Starvation: continuous pipe_valid starves the buffer. This is legal; md_ready then stays low once full.

Decomposition:
- Package wb_pkg:
  - typedef wb_req_t {logic [ADDRESS_WIDTH-1:0] rd; logic [D_WIDTH-1:0] data;};
  - enum wb_src_e {WB_NONE, WB_PIPE, WB_MD};
  - localparam REG_X0 = 0.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_req_t with push/pop/full/empty/count, async active-high reset.
- Arbiter, scoreboard and output registers stay in wb_arbiter.

Test Plan:
- Reset then pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF → next cycle rf_wr_en=1, rf_a3=5, rf_din=0xDEADBEEF; after the negedge the register file reads x5=0xDEADBEEF.
- issue_valid with issue_rd=7; rs1=7 in decode → stall=1. md result rd=7, data=0x12 while pipe idle → pushed, popped the next cycle: rf_a3=7, rf_din=0x12; stall=0 the following cycle.
- Two md results (rd=3 then rd=4) while pipe_valid stays 1 for 4 cycles → md_ready=0 after two pushes, no rf write from md. Pipe drops → rd=3 then rd=4 written on consecutive cycles, in order; md_ready returns to 1.
- Pipe write or md result with rd=0, data=0xFFFF → rf_wr_en=0; a buffered x0 entry is popped; count decrements.
- Same-cycle issue_rd=9 and pop of a buffered rd=9 entry → pend[9] stays 1; stall on rs2=9 persists.
- Assert rst while the buffer holds 2 entries and pend[6]=1 → rf_wr_en=0 immediately, stall=0, md_ready=1 after release; the old entries are never written.
